// File: rtl/hls_mem_responder.sv
// Word-addressed memory responder for the HLS-side data-bus FIFOs.
// Pops command beats together, does masked writes, and streams read bursts.
module hls_mem_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int DEPTH           = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_ADDR_WIDTH-1:0] io_bus_cmd_payload_address_V_dout,
    input  logic                       io_bus_cmd_payload_address_V_empty_n,
    output logic                       io_bus_cmd_payload_address_V_read,
    input  logic [DATA_WIDTH-1:0]      io_bus_cmd_payload_data_V_dout,
    input  logic                       io_bus_cmd_payload_data_V_empty_n,
    output logic                       io_bus_cmd_payload_data_V_read,
    input  logic [3:0]                 io_bus_cmd_payload_mask_V_dout,
    input  logic                       io_bus_cmd_payload_mask_V_empty_n,
    output logic                       io_bus_cmd_payload_mask_V_read,
    input  logic                       io_bus_cmd_payload_write_V_dout,
    input  logic                       io_bus_cmd_payload_write_V_empty_n,
    output logic                       io_bus_cmd_payload_write_V_read,
    input  logic                       io_bus_cmd_payload_uncached_V_dout,
    input  logic                       io_bus_cmd_payload_uncached_V_empty_n,
    output logic                       io_bus_cmd_payload_uncached_V_read,
    input  logic [2:0]                 io_bus_cmd_payload_size_V_dout,
    input  logic                       io_bus_cmd_payload_size_V_empty_n,
    output logic                       io_bus_cmd_payload_size_V_read,
    input  logic                       io_bus_cmd_payload_last_V_dout,
    input  logic                       io_bus_cmd_payload_last_V_empty_n,
    output logic                       io_bus_cmd_payload_last_V_read,
    output logic [DATA_WIDTH-1:0]      io_bus_rsp_payload_data_V_din,
    input  logic                       io_bus_rsp_payload_data_V_full_n,
    output logic                       io_bus_rsp_payload_data_V_write,
    output logic                       io_bus_rsp_payload_last_V_din,
    input  logic                       io_bus_rsp_payload_last_V_full_n,
    output logic                       io_bus_rsp_payload_last_V_write
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]            r_state;
    logic [AW-1:0]         r_base;
    logic [5:0]            r_beat;
    logic [5:0]            r_beats;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic          w_cmd_ok;
    logic          w_rsp_ok;
    logic          w_pop;
    logic          w_push;
    logic          w_last;
    logic [2:0]    w_shift;
    logic [5:0]    w_beats;
    logic [AW-1:0] w_waddr;
    logic [31:0]   w_sum;
    logic [AW-1:0] w_ridx;
    logic          w_unused_ok;

    assign w_cmd_ok = io_bus_cmd_payload_address_V_empty_n
                    & io_bus_cmd_payload_data_V_empty_n
                    & io_bus_cmd_payload_mask_V_empty_n
                    & io_bus_cmd_payload_write_V_empty_n
                    & io_bus_cmd_payload_uncached_V_empty_n
                    & io_bus_cmd_payload_size_V_empty_n
                    & io_bus_cmd_payload_last_V_empty_n;

    assign w_rsp_ok = io_bus_rsp_payload_data_V_full_n
                    & io_bus_rsp_payload_last_V_full_n;

    // Strobes are gated by rst so nothing moves while reset is held.
    assign w_pop  = !rst && (r_state == ST_IDLE) && w_cmd_ok;
    assign w_push = !rst && (r_state == ST_BURST) && w_rsp_ok;

    assign io_bus_cmd_payload_address_V_read  = w_pop;
    assign io_bus_cmd_payload_data_V_read     = w_pop;
    assign io_bus_cmd_payload_mask_V_read     = w_pop;
    assign io_bus_cmd_payload_write_V_read    = w_pop;
    assign io_bus_cmd_payload_uncached_V_read = w_pop;
    assign io_bus_cmd_payload_size_V_read     = w_pop;
    assign io_bus_cmd_payload_last_V_read     = w_pop;

    assign io_bus_rsp_payload_data_V_write = w_push;
    assign io_bus_rsp_payload_last_V_write = w_push;

    assign w_shift = io_bus_cmd_payload_size_V_dout - 3'd2;
    assign w_beats = (io_bus_cmd_payload_size_V_dout <= 3'd2)
                   ? 6'd1 : (6'd1 << w_shift);

    assign w_waddr = io_bus_cmd_payload_address_V_dout[AW-1:0];
    assign w_sum   = 32'(r_base) + 32'(r_beat);
    assign w_ridx  = w_sum[AW-1:0];
    assign w_last  = (r_beat == r_beats - 6'd1);

    assign io_bus_rsp_payload_data_V_din = r_mem[w_ridx];
    assign io_bus_rsp_payload_last_V_din = w_last;

    assign w_unused_ok = ^{io_bus_cmd_payload_address_V_dout,
                           io_bus_cmd_payload_uncached_V_dout,
                           io_bus_cmd_payload_last_V_dout,
                           w_sum};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
            r_beat  <= '0;
            r_beats <= '0;
        end else if (w_pop && !io_bus_cmd_payload_write_V_dout) begin
            r_state <= ST_BURST;
            r_base  <= w_waddr;
            r_beat  <= '0;
            r_beats <= w_beats;
        end else if (w_push) begin
            r_beat <= r_beat + 6'd1;
            if (w_last) begin
                r_state <= ST_IDLE;
            end
        end
    end

    // Array is not reset; only enabled bytes of a popped write change.
    always_ff @(posedge clk) begin
        if (w_pop && io_bus_cmd_payload_write_V_dout) begin
            for (int i = 0; i < 4; i++) begin
                if (io_bus_cmd_payload_mask_V_dout[i]) begin
                    r_mem[w_waddr][8*i +: 8] <= io_bus_cmd_payload_data_V_dout[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_hls_mem_responder.sv
// Directed bench for hls_mem_responder: vector table plus burst,
// backpressure, wrap and mid-burst reset sequences.
module tb_hls_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] c_addr;
    logic [31:0] c_data;
    logic [3:0]  c_mask;
    logic        c_wr;
    logic        c_unc;
    logic [2:0]  c_size;
    logic        c_lst;
    logic [6:0]  en;
    logic [6:0]  rd;
    logic [31:0] r_data;
    logic        r_last;
    logic        full_d;
    logic        full_l;
    logic        wr_d;
    logic        wr_l;

    int checks = 0;
    int fails  = 0;

    logic        s_pop;
    logic        s_push;
    logic [31:0] s_data;
    logic        s_last;

    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    hls_mem_responder #(
        .DATA_WIDTH(32),
        .DATA_ADDR_WIDTH(32),
        .DEPTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io_bus_cmd_payload_address_V_dout(c_addr),
        .io_bus_cmd_payload_address_V_empty_n(en[0]),
        .io_bus_cmd_payload_address_V_read(rd[0]),
        .io_bus_cmd_payload_data_V_dout(c_data),
        .io_bus_cmd_payload_data_V_empty_n(en[1]),
        .io_bus_cmd_payload_data_V_read(rd[1]),
        .io_bus_cmd_payload_mask_V_dout(c_mask),
        .io_bus_cmd_payload_mask_V_empty_n(en[2]),
        .io_bus_cmd_payload_mask_V_read(rd[2]),
        .io_bus_cmd_payload_write_V_dout(c_wr),
        .io_bus_cmd_payload_write_V_empty_n(en[3]),
        .io_bus_cmd_payload_write_V_read(rd[3]),
        .io_bus_cmd_payload_uncached_V_dout(c_unc),
        .io_bus_cmd_payload_uncached_V_empty_n(en[4]),
        .io_bus_cmd_payload_uncached_V_read(rd[4]),
        .io_bus_cmd_payload_size_V_dout(c_size),
        .io_bus_cmd_payload_size_V_empty_n(en[5]),
        .io_bus_cmd_payload_size_V_read(rd[5]),
        .io_bus_cmd_payload_last_V_dout(c_lst),
        .io_bus_cmd_payload_last_V_empty_n(en[6]),
        .io_bus_cmd_payload_last_V_read(rd[6]),
        .io_bus_rsp_payload_data_V_din(r_data),
        .io_bus_rsp_payload_data_V_full_n(full_d),
        .io_bus_rsp_payload_data_V_write(wr_d),
        .io_bus_rsp_payload_last_V_din(r_last),
        .io_bus_rsp_payload_last_V_full_n(full_l),
        .io_bus_rsp_payload_last_V_write(wr_l)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs are driven just after negedge; sample 1ns later, then advance.
    task automatic step();
        #1;
        s_pop  = rd[0];
        s_push = wr_d;
        s_data = r_data;
        s_last = r_last;
        chk("rd_tied", 32'(rd), 32'(rd[0] ? 7'h7F : 7'h00));
        chk("wr_tied", 32'(wr_l), 32'(wr_d));
        @(negedge clk);
    endtask

    task automatic do_cmd(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m,
                          input logic [2:0] s);
        c_wr = w; c_addr = a; c_data = d; c_mask = m; c_size = s;
        en = 7'h7F;
        step();
        chk("pop", 32'(s_pop), 32'd1);
        c_wr = 1'b1; c_addr = 32'd7; c_data = 32'hFFFF_FFFF; c_mask = 4'h0;
        c_size = 3'd2;
    endtask

    task automatic burst(input logic [31:0] a, input logic [2:0] s,
                         input int nexp, input int stall_at,
                         input int stall_len, input bit stall_last,
                         input int rst_at);
        int got = 0;
        int cyc = 0;
        int scnt = 0;
        bit rdone = 0;
        do_cmd(1'b0, a, 32'h0, 4'h0, s);
        while (got < nexp && cyc < 200) begin
            bit stall = (got == stall_at) && (scnt < stall_len);
            full_d = !(stall && !stall_last);
            full_l = !(stall && stall_last);
            if (got == rst_at && !rdone) rst = 1'b1;
            step();
            cyc++;
            full_d = 1'b1;
            full_l = 1'b1;
            if (rst) begin
                chk("rst_nopush", 32'(s_push), 32'd0);
                chk("rst_nopop", 32'(s_pop), 32'd0);
                rst = 1'b0;
                rdone = 1;
                break;
            end else if (stall) begin
                chk("stall_nopush", 32'(s_push), 32'd0);
                scnt++;
            end else begin
                chk("push", 32'(s_push), 32'd1);
                chk("beat_data", s_data, exp_q[got]);
                chk("beat_last", 32'(s_last), 32'(got == nexp - 1));
                chk("burst_nopop", 32'(s_pop), 32'd0);
                got++;
            end
        end
        if (cyc >= 200) begin
            fails++;
            $display("FAIL burst_timeout: got %0d beats expected %0d", got, nexp);
        end
        step();
        chk("next_pop", 32'(s_pop), 32'd1);
        chk("next_nopush", 32'(s_push), 32'd0);
        en = 7'h00;
        if (rdone) begin
            step();
            chk("after_rst_nopush", 32'(s_push), 32'd0);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [2:0]  size;
        logic [31:0] exp;
    } vec_t;

    vec_t tv [11];

    initial begin
        tv[0]  = '{1, 32'd3,  32'hDEADBEEF, 4'hF, 3'd2, 32'h0};
        tv[1]  = '{0, 32'd3,  32'h0,        4'h0, 3'd2, 32'hDEADBEEF};
        tv[2]  = '{1, 32'd3,  32'h11223344, 4'h5, 3'd2, 32'h0};
        tv[3]  = '{0, 32'd3,  32'h0,        4'h0, 3'd2, 32'hDE22BE44};
        tv[4]  = '{1, 32'd5,  32'h01020304, 4'hF, 3'd2, 32'h0};
        tv[5]  = '{1, 32'd5,  32'hAABBCCDD, 4'h8, 3'd2, 32'h0};
        tv[6]  = '{1, 32'd5,  32'h0000EE00, 4'h2, 3'd2, 32'h0};
        tv[7]  = '{0, 32'd5,  32'h0,        4'h0, 3'd0, 32'hAA02EE04};
        tv[8]  = '{0, 32'd19, 32'h0,        4'h0, 3'd1, 32'hDE22BE44};
        tv[9]  = '{1, 32'd21, 32'hFFFFFFFF, 4'h0, 3'd2, 32'h0};
        tv[10] = '{0, 32'd5,  32'h0,        4'h0, 3'd2, 32'hAA02EE04};

        rst = 1'b1;
        c_addr = 0; c_data = 0; c_mask = 0; c_wr = 0;
        c_unc = 0; c_size = 0; c_lst = 0;
        en = 7'h7F; full_d = 1'b1; full_l = 1'b1;
        @(negedge clk);
        step();
        chk("rst_pop", 32'(s_pop), 32'd0);
        chk("rst_push", 32'(s_push), 32'd0);
        rst = 1'b0;
        en = 7'h00;
        step();
        chk("idle_pop", 32'(s_pop), 32'd0);
        chk("idle_push", 32'(s_push), 32'd0);
        en = 7'h5F;
        step();
        chk("partial_pop", 32'(s_pop), 32'd0);
        en = 7'h00;

        for (int i = 0; i < 11; i++) begin
            if (tv[i].wr) begin
                do_cmd(1'b1, tv[i].addr, tv[i].data, tv[i].mask, tv[i].size);
                en = 7'h00;
            end else begin
                exp_q = {tv[i].exp};
                burst(tv[i].addr, tv[i].size, 1, -1, 0, 0, -1);
            end
        end

        for (int i = 8; i < 16; i++) begin
            do_cmd(1'b1, 32'(i), 32'h100 + 32'(i), 4'hF, 3'd2);
        end
        en = 7'h00;
        exp_q = {};
        for (int i = 8; i < 16; i++) exp_q.push_back(32'h100 + 32'(i));
        burst(32'd8, 3'd5, 8, -1, 0, 0, -1);
        burst(32'd8, 3'd5, 8, 2, 3, 0, -1);
        burst(32'd8, 3'd5, 8, 5, 2, 1, -1);
        burst(32'd8, 3'd5, 8, -1, 0, 0, 4);
        burst(32'd8, 3'd5, 8, -1, 0, 0, -1);

        do_cmd(1'b1, 32'd14, 32'hA0, 4'hF, 3'd2);
        do_cmd(1'b1, 32'd15, 32'hA1, 4'hF, 3'd2);
        do_cmd(1'b1, 32'd0,  32'hA2, 4'hF, 3'd2);
        do_cmd(1'b1, 32'd1,  32'hA3, 4'hF, 3'd2);
        en = 7'h00;
        exp_q = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
        burst(32'd14, 3'd4, 4, -1, 0, 0, -1);

        for (int i = 0; i < 16; i++) begin
            do_cmd(1'b1, 32'(i), 32'h5000 + 32'(i), 4'hF, 3'd2);
        end
        en = 7'h00;
        exp_q = {};
        for (int i = 0; i < 32; i++) exp_q.push_back(32'h5000 + 32'(i % 16));
        burst(32'd0, 3'd7, 32, -1, 0, 0, -1);
        exp_q = {32'h500F, 32'h5000};
        burst(32'd15, 3'd3, 2, -1, 0, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
